// File: rtl/gaussian_frame_ctrl.sv
// gaussian_frame_ctrl: gaussian filter frame sequencer (clear, admit W*H pixels, count outputs, pulse done); GFC_TIMEOUT_EN adds a drain watchdog
module gaussian_frame_ctrl #(
  parameter int IMAGE_WIDTH    = 640,
  parameter int IMAGE_HEIGHT   = 480,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        flt_in_valid,
  input  logic        flt_in_ready,
  input  logic        flt_out_valid,
  input  logic        flt_out_ready,
  output logic        flt_clear,
  output logic [15:0] frame_cnt
);
  localparam int N_IN  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int N_OUT = (IMAGE_WIDTH - 2) * (IMAGE_HEIGHT - 2);
  localparam int IW    = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam int OW    = N_OUT > 1 ? $clog2(N_OUT) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] in_cnt;
  logic [OW-1:0] out_cnt;
  logic          in_done, out_done;
  logic          in_hs, out_hs, in_last, out_last, out_fin, timeout;

  assign in_hs        = state == STREAM && src_valid && flt_in_ready;
  assign out_hs       = (state == STREAM || state == DRAIN) && !out_done && flt_out_valid && flt_out_ready;
  assign in_last      = in_hs && in_cnt == IW'(N_IN - 1);
  assign out_last     = out_hs && out_cnt == OW'(N_OUT - 1);
  assign out_fin      = out_done || out_last;
  assign busy         = state != IDLE;
  assign done         = state == DONE;
  assign flt_clear    = state == CLEAR;
  assign src_ready    = state == STREAM && flt_in_ready;
  assign flt_in_valid = state == STREAM && src_valid;

`ifdef GFC_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall;
  logic          abort;
  assign timeout = state == DRAIN && !out_hs && stall == SW'(TIMEOUT_CYCLES - 1);
  assign err     = state == DONE && abort;
  // drain stall counter and a flag marking the coming DONE as a watchdog abort
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall <= '0;
      abort <= 1'b0;
    end else begin
      stall <= (state == DRAIN && !out_hs) ? stall + SW'(1) : '0;
      abort <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next state; DONE is reached as soon as both sides finish, even in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? CLEAR : IDLE;
      CLEAR:   state_nxt = STREAM;
      STREAM:  state_nxt = in_last ? (out_fin ? DONE : DRAIN) : STREAM;
      DRAIN:   state_nxt = ((in_done && out_fin) || timeout) ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end

  // pixel counters, completion flags and the completed-frame counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      in_done   <= 1'b0;
      out_done  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (state == IDLE && start) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (in_hs)  in_cnt  <= in_cnt + IW'(1);
        if (out_hs) out_cnt <= out_cnt + OW'(1);
      end
      if (state == CLEAR) begin
        in_done  <= 1'b0;
        out_done <= 1'b0;
      end else begin
        if (in_last)  in_done  <= 1'b1;
        if (out_last) out_done <= 1'b1;
      end
      if (state == DONE && !err) frame_cnt <= frame_cnt + 16'd1;
    end
  end
endmodule
